maxnet_sequencer: RTL and testbench

- Host-side companion to the Maxnet top module: the block that drives `start` and consumes `maxnumber`.
- Collects NUM_INPUTS operand words from a valid/ready input stream into a holding buffer and presents them in parallel to the Maxnet.
- Pulses the Maxnet start, waits for its done flag, captures the 32-bit maximum and returns it on a valid/ready result port.
- Sits between the stimulus/DMA source and the Maxnet core; replaces hand-driven start sequencing.

---
 rtl/maxnet_sequencer.sv | 112 +++++++++++
 tb/tb_maxnet_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_sequencer.sv
// maxnet_sequencer: gathers NUM_INPUTS operands, runs one Maxnet pass, returns its max.
// Define MAXNET_TIMEOUT_EN to bound the wait for mx_done and raise a sticky error.
module maxnet_sequencer #(
   parameter int WIDTH          = 32,
   parameter int NUM_INPUTS     = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   output logic [NUM_INPUTS*WIDTH-1:0] mx_operands,
   output logic                        mx_start,
   input  logic                        mx_done,
   input  logic [WIDTH-1:0]            mx_max,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic                        busy,
   output logic                        error
);
   localparam int CW = $clog2(NUM_INPUTS);
   localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {
      S_COLLECT,
      S_START,
      S_WAIT,
      S_RESULT
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [CW-1:0]               r_cnt;
   logic [NUM_INPUTS*WIDTH-1:0] r_ops;
   logic [WIDTH-1:0]            r_data;
   logic                        w_accept;
   logic                        w_timeout;

   // in_ready is gated by rst so nothing is accepted while held in reset
   assign in_ready    = rst & (r_state == S_COLLECT);
   assign w_accept    = in_valid & in_ready;
   assign mx_start    = (r_state == S_START);
   assign out_valid   = (r_state == S_RESULT);
   assign busy        = (r_state != S_COLLECT) | (r_cnt != '0);
   assign mx_operands = r_ops;
   assign out_data    = r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_COLLECT;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_COLLECT: if (w_accept && r_cnt == LAST) w_next = S_START;
         S_START:   w_next = S_WAIT;
         S_WAIT:    if (mx_done || w_timeout) w_next = S_RESULT;
         S_RESULT:  if (out_ready) w_next = S_COLLECT;
         default:   w_next = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_ops <= '0;
      end else if (w_accept) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_cnt == CW'(i)) r_ops[i*WIDTH +: WIDTH] <= in_data;
         end
      end
   end

   // done is only honoured in WAIT; a timeout returns an all-ones word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
      end else if (r_state == S_WAIT) begin
         if (mx_done)        r_data <= mx_max;
         else if (w_timeout) r_data <= '1;
      end
   end

`ifdef MAXNET_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_tmo;
   logic          r_err;

   assign w_timeout = (r_state == S_WAIT) & ~mx_done &
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));
   assign error     = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         r_tmo <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;
         if (w_timeout) r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_sequencer.sv
// tb_maxnet_sequencer: scenario tasks with a result scoreboard queue.
// The timeout scenario runs only when MAXNET_TIMEOUT_EN is defined.
module tb_maxnet_sequencer;
   localparam int W = 32;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic [N*W-1:0] mx_operands;
   logic           mx_start;
   logic           mx_done = 1'b0;
   logic [W-1:0]   mx_max = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic           busy;
   logic           error;

   int n_cmp = 0;
   int n_err = 0;
   int n_start = 0;
   int n_acc = 0;
   int n_hs = 0;
   logic [W-1:0] exp_q[$];

   maxnet_sequencer #(
      .WIDTH(W), .NUM_INPUTS(N), .TIMEOUT_CYCLES(15)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mx_operands(mx_operands), .mx_start(mx_start),
      .mx_done(mx_done), .mx_max(mx_max),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         if (mx_start) n_start <= n_start + 1;
         if (in_valid && in_ready) n_acc <= n_acc + 1;
         if (out_valid && out_ready) n_hs <= n_hs + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input bit gap);
      int g = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) begin
         n_cmp++; n_err++;
         $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic pulse_done(input logic [W-1:0] m);
      mx_done = 1'b1;
      mx_max  = m;
      tick();
      mx_done = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++;
      if ({in_ready, mx_start, out_valid, busy, error} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {in_ready, mx_start, out_valid, busy, error});
      end
      n_cmp++;
      if (mx_operands !== '0) begin
         n_err++;
         $display("FAIL reset_ops: got %h required 0", mx_operands);
      end
      n_cmp++;
      if (out_data !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h required 0", out_data);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int s = n_start;
      int a = n_acc;
      int h = n_hs;
      logic [W-1:0] e;
      logic [N*W-1:0] ops = {32'h9, 32'h3, 32'h11, 32'h5};
      exp_q.push_back(32'h11);
      send(32'h5, 0); send(32'h11, 0); send(32'h3, 0); send(32'h9, 0);
      n_cmp++;
      if (mx_start !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL basic_start: start=%b ready=%b required 1 0",
                  mx_start, in_ready);
      end
      n_cmp++;
      if (mx_operands !== ops) begin
         n_err++;
         $display("FAIL basic_ops: got %h required %h", mx_operands, ops);
      end
      tick();
      n_cmp++;
      if (mx_start !== 1'b0) begin
         n_err++;
         $display("FAIL basic_start_width: start=%b required 0", mx_start);
      end
      repeat (5) tick();
      pulse_done(32'h11);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (out_data !== e || mx_operands !== ops) begin
         n_err++;
         $display("FAIL basic_data: got %h ops %h required %h ops %h",
                  out_data, mx_operands, e, ops);
      end
      consume();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL basic_return: valid=%b ready=%b required 0 1",
                  out_valid, in_ready);
      end
      n_cmp++;
      if (n_start - s != 1 || n_acc - a != 4 || n_hs - h != 1) begin
         n_err++;
         $display("FAIL basic_counts: start=%0d acc=%0d hs=%0d required 1 4 1",
                  n_start - s, n_acc - a, n_hs - h);
      end
   endtask

   task automatic test_gaps();
      int s = n_start;
      int a = n_acc;
      logic [W-1:0] e;
      logic [N*W-1:0] ops = {32'h30, 32'h20, 32'h40, 32'h10};
      exp_q.push_back(32'h40);
      send(32'h10, 1); send(32'h40, 1); send(32'h20, 1);
      n_cmp++;
      if (n_start != s || in_ready !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL gaps_early: starts=%0d ready=%b busy=%b required 0 1 1",
                  n_start - s, in_ready, busy);
      end
      send(32'h30, 0);
      n_cmp++;
      if (mx_start !== 1'b1 || mx_operands !== ops) begin
         n_err++;
         $display("FAIL gaps_start: start=%b ops=%h required 1 %h",
                  mx_start, mx_operands, ops);
      end
      tick(); tick();
      pulse_done(32'h40);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== e) begin
         n_err++;
         $display("FAIL gaps_data: valid=%b data=%h required 1 %h",
                  out_valid, out_data, e);
      end
      consume();
      n_cmp++;
      if (n_acc - a != 4 || n_start - s != 1) begin
         n_err++;
         $display("FAIL gaps_counts: acc=%0d start=%0d required 4 1",
                  n_acc - a, n_start - s);
      end
   endtask

   task automatic test_backpressure();
      int h = n_hs;
      int bad = 0;
      logic [W-1:0] e;
      exp_q.push_back(32'hFFFF_FFFE);
      send(32'h7FFF_FFFF, 0); send(32'h8000_0000, 0);
      send(32'h1, 0); send(32'hFFFF_FFFE, 0);
      tick(); tick();
      pulse_done(32'hFFFF_FFFE);
      e = exp_q.pop_front();
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: cyc %0d valid=%b data=%h ready=%b required 1 %h 0",
                     i, out_valid, out_data, in_ready, e);
         end
         tick();
      end
      consume();
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || n_hs - h != 1) begin
         n_err++;
         $display("FAIL bp_handshake: valid=%b hs=%0d required 0 1",
                  out_valid, n_hs - h);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit seen = 0;
      logic [W-1:0] e;
      send(32'h100, 0); send(32'h200, 0); send(32'h300, 0); send(32'h400, 0);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, mx_start, out_valid, busy, error} !== 5'b0 ||
          mx_operands !== '0 || out_data !== '0) begin
         n_err++;
         $display("FAIL rst_mid: ctrl=%b ops=%h data=%h required 0 0 0",
                  {in_ready, mx_start, out_valid, busy, error},
                  mx_operands, out_data);
      end
      tick(); tick();
      rst = 1'b1;
      pulse_done(32'hDEAD);
      for (int i = 0; i < 5; i++) begin
         if (out_valid || mx_start) seen = 1;
         tick();
      end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL rst_no_result: out seen=1 required 0");
      end
      exp_q.push_back(32'h55);
      send(32'h55, 0); send(32'h1, 0); send(32'h2, 0); send(32'h3, 0);
      tick(); tick();
      pulse_done(32'h55);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== e) begin
         n_err++;
         $display("FAIL rst_rerun: valid=%b data=%h required 1 %h",
                  out_valid, out_data, e);
      end
      consume();
   endtask

   task automatic test_spurious_done();
      logic [W-1:0] e;
      exp_q.push_back(32'hCAFE_F00D);
      send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 0);
      mx_done = 1'b1;
      mx_max  = 32'h1234_5678;
      tick();
      mx_done = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL spur_ignored: out_valid=%b required 0", out_valid);
      end
      tick();
      pulse_done(32'hCAFE_F00D);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== e) begin
         n_err++;
         $display("FAIL spur_data: valid=%b data=%h required 1 %h",
                  out_valid, out_data, e);
      end
      consume();
   endtask

`ifdef MAXNET_TIMEOUT_EN
   task automatic test_timeout();
      int c = 0;
      logic [W-1:0] e;
      exp_q.push_back(32'hFFFF_FFFF);
      send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 0);
      while (!out_valid && c < 40) begin
         tick();
         c++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (c != 16 || error !== 1'b1 || out_data !== e) begin
         n_err++;
         $display("FAIL timeout: cycles=%0d err=%b data=%h required 16 1 %h",
                  c, error, out_data, e);
      end
      consume();
      pulse_done(32'h77);
      n_cmp++;
      if (error !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_sticky: err=%b valid=%b required 1 0",
                  error, out_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_backpressure();
      test_reset_mid_wait();
      test_spurious_done();
`ifdef MAXNET_TIMEOUT_EN
      test_timeout();
`else
      n_cmp++;
      if (error !== 1'b0) begin
         n_err++;
         $display("FAIL error_tied: err=%b required 0", error);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
